pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection with a deferred branch
// slot for stalled cycles and a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       INC       = 1,
  parameter logic [ADDR_W-1:0] RST_VEC   = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(4),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              call,
  input  logic              ret,
  input  logic              trap,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              redirect,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_uflow
);

  localparam int unsigned PtrW    = $clog2(RAS_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q;
  logic              redirect_q, redirect_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [PtrW-1:0]   sp_q, sp_d;
  logic [PtrW:0]     cnt_q, cnt_d;
  logic              uflow_q, uflow_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic              push;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] ras_top;

  assign pc_inc  = pc_q + ADDR_W'(INC);
  assign ras_top = ras_q[sp_q - PtrW'(1)];

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    uflow_d    = uflow_q;
    push       = 1'b0;
    // The first edge out of reset only raises pc_valid; pc stays at RST_VEC.
    if (!pc_valid_q) begin
      pc_d = pc_q;
    end else if (trap) begin
      pc_d       = TRAP_VEC;
      redirect_d = 1'b1;
      pend_v_d   = 1'b0;
    end else if (stall) begin
      if (br_take) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = br_target;
      end
    end else if (ret) begin
      redirect_d = 1'b1;
      pend_v_d   = 1'b0;
      if (cnt_q != '0) begin
        pc_d  = ras_top;
        sp_d  = sp_q - PtrW'(1);
        cnt_d = cnt_q - 1'b1;
      end else begin
        pc_d    = TRAP_VEC;
        uflow_d = 1'b1;
      end
    end else if (jmp) begin
      pc_d       = jmp_target;
      redirect_d = 1'b1;
      pend_v_d   = 1'b0;
      if (call) begin
        // When full, sp already points at the oldest entry, so it is overwritten.
        push = 1'b1;
        sp_d = sp_q + PtrW'(1);
        if (cnt_q != FullCnt) cnt_d = cnt_q + 1'b1;
      end
    end else if (br_take) begin
      pc_d       = br_target;
      redirect_d = 1'b1;
      pend_v_d   = 1'b0;
    end else if (pend_v_q) begin
      pc_d       = pend_tgt_q;
      redirect_d = 1'b1;
      pend_v_d   = 1'b0;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RST_VEC;
      pc_valid_q <= 1'b0;
      redirect_q <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
      sp_q       <= '0;
      cnt_q      <= '0;
      uflow_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      redirect_q <= redirect_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
      uflow_q    <= uflow_d;
    end
  end

  // Stack storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) ras_q[sp_q] <= pc_inc;
  end

  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign redirect  = redirect_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FullCnt);
  assign ras_uflow = uflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, wrap, stalled branch, trap, RAS overflow,
// same-cycle call/ret and mid-run reset.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_take;
  logic [15:0] br_target;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        call;
  logic        ret;
  logic        trap;
  logic [15:0] pc;
  logic        pc_valid;
  logic        redirect;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_uflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_take   (br_take),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .call      (call),
    .ret       (ret),
    .trap      (trap),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .redirect  (redirect),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_uflow (ras_uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [15:0] tgt);
    jmp = 1'b1; call = 1'b1; jmp_target = tgt;
    step();
    jmp = 1'b0; call = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_take = 1'b0; br_target = '0;
    jmp = 1'b0; jmp_target = '0; call = 1'b0; ret = 1'b0; trap = 1'b0;
    #3;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_valid", 32'(pc_valid), 32'h0);
    check("rst_redirect", 32'(redirect), 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_full", 32'(ras_full), 32'h0);
    check("rst_uflow", 32'(ras_uflow), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("first_valid", 32'(pc_valid), 32'h1);
    check("first_pc_hold", 32'(pc), 32'h0);
    step();
    check("seq_start", 32'(pc), 32'h1);

    // Sequential wrap
    jmp = 1'b1; jmp_target = 16'hFFFE;
    step();
    jmp = 1'b0;
    check("wrap_jmp_pc", 32'(pc), 32'hFFFE);
    check("wrap_jmp_redirect", 32'(redirect), 32'h1);
    step();
    check("wrap_ffff", 32'(pc), 32'hFFFF);
    check("wrap_ffff_redirect", 32'(redirect), 32'h0);
    step();
    check("wrap_zero", 32'(pc), 32'h0);
    check("wrap_zero_redirect", 32'(redirect), 32'h0);

    // Branch under stall
    stall = 1'b1; br_take = 1'b1; br_target = 16'h0100;
    step();
    br_take = 1'b0;
    check("stall_br_hold1", 32'(pc), 32'h0);
    check("stall_br_redir", 32'(redirect), 32'h0);
    step();
    step();
    check("stall_br_hold3", 32'(pc), 32'h0);
    stall = 1'b0;
    step();
    check("pend_load_pc", 32'(pc), 32'h0100);
    check("pend_load_redirect", 32'(redirect), 32'h1);
    step();
    check("pend_after_pc", 32'(pc), 32'h0101);
    check("pend_after_redirect", 32'(redirect), 32'h0);

    // Trap overrides a pending branch during stall
    stall = 1'b1; br_take = 1'b1; br_target = 16'h0200;
    step();
    br_take = 1'b0; trap = 1'b1;
    step();
    trap = 1'b0;
    check("trap_pc", 32'(pc), 32'h4);
    check("trap_redirect", 32'(redirect), 32'h1);
    step();
    check("trap_stall_hold", 32'(pc), 32'h4);
    stall = 1'b0;
    step();
    check("trap_pend_cleared", 32'(pc), 32'h5);

    // RAS overflow: calls from 10,20,30,40,50
    jmp = 1'b1; jmp_target = 16'd10;
    step();
    jmp = 1'b0;
    check("ovf_start", 32'(pc), 32'd10);
    do_call(16'd20);
    do_call(16'd30);
    do_call(16'd40);
    check("ovf_not_full", 32'(ras_full), 32'h0);
    do_call(16'd50);
    check("ovf_full4", 32'(ras_full), 32'h1);
    do_call(16'd60);
    check("ovf_pc60", 32'(pc), 32'd60);
    check("ovf_full5", 32'(ras_full), 32'h1);
    ret = 1'b1;
    step();
    check("ret1", 32'(pc), 32'd51);
    check("ret1_full", 32'(ras_full), 32'h0);
    step();
    check("ret2", 32'(pc), 32'd41);
    step();
    check("ret3", 32'(pc), 32'd31);
    step();
    check("ret4", 32'(pc), 32'd21);
    check("ret4_empty", 32'(ras_empty), 32'h1);
    check("ret4_uflow", 32'(ras_uflow), 32'h0);
    step();
    ret = 1'b0;
    check("ret5_trap", 32'(pc), 32'h4);
    check("ret5_uflow", 32'(ras_uflow), 32'h1);
    check("ret5_redirect", 32'(redirect), 32'h1);

    // Call and ret together: ret wins, one pop, no push
    jmp = 1'b1; jmp_target = 16'h0010;
    step();
    jmp = 1'b0;
    do_call(16'h0080);
    check("cr_pc80", 32'(pc), 32'h0080);
    check("cr_nonempty", 32'(ras_empty), 32'h0);
    jmp = 1'b1; call = 1'b1; ret = 1'b1; jmp_target = 16'h0090;
    step();
    jmp = 1'b0; call = 1'b0; ret = 1'b0;
    check("cr_pc", 32'(pc), 32'h0011);
    check("cr_empty", 32'(ras_empty), 32'h1);
    check("cr_uflow_sticky", 32'(ras_uflow), 32'h1);

    // Reset mid-run with pending branch and two RAS entries
    do_call(16'h0100);
    do_call(16'h0200);
    stall = 1'b1; br_take = 1'b1; br_target = 16'h0300;
    step();
    br_take = 1'b0; stall = 1'b0;
    check("mr_pre_pc", 32'(pc), 32'h0200);
    rst_n = 1'b0;
    #1;
    check("mr_pc", 32'(pc), 32'h0);
    check("mr_valid", 32'(pc_valid), 32'h0);
    check("mr_empty", 32'(ras_empty), 32'h1);
    check("mr_uflow", 32'(ras_uflow), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_valid_rel", 32'(pc_valid), 32'h1);
    check("mr_pc_rel", 32'(pc), 32'h0);
    step();
    check("mr_no_pending", 32'(pc), 32'h1);
    check("mr_no_redirect", 32'(redirect), 32'h0);
    ret = 1'b1;
    step();
    ret = 1'b0;
    check("mr_ras_gone", 32'(pc), 32'h4);
    check("mr_ras_uflow", 32'(ras_uflow), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
